serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial multi-bit adder built around the existing single-bit `FullAdder`. It is the stage directly upstream of, and the consumer of, that full adder. It latches two WIDTH-bit operands and a carry-in, then feeds the `FullAdder` one bit pair per clock, LSB first. Between bits it holds CARRY in a flip-flop that drives CIN on the next cycle. It presents the WIDTH-bit sum and final carry with a start/busy/done handshake. It is the first sequential arithmetic block in the design and trades latency for a single adder cell.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2 to 32.
- `CLK`  input  1: the single clock; all state updates on the rising edge.
- `RST`  input  1: synchronous, active-high reset, sampled on the rising edge of `CLK`.
- `START`  input  1: request to begin an addition; sampled on the rising edge.
- `A`  input  WIDTH: operand A; sampled only on the accepting edge.
- `B`  input  WIDTH: operand B; sampled only on the accepting edge.
- `CIN`  input  1: carry into bit 0; sampled only on the accepting edge.
- `BUSY`  output  1: high while bits are being processed.
- `DONE`  output  1: one-cycle pulse when `SUM`/`COUT` take a new result.
- `SUM`  output  WIDTH: result register; holds the last completed sum.
- `COUT`  output  1: carry out of bit WIDTH-1 for the last completed sum.

## Operation
- One `FullAdder` instance:
  - A input = LSB of the A shift register.
  - B input = LSB of the B shift register.
  - CIN input = carry flip-flop.
- State machine with three states: IDLE, RUN, FIN.
- IDLE or FIN with `START`=1 accepts a new operation:
  - load `A`/`B` into the shift registers;
  - carry flip-flop ← `CIN`;
  - bit counter ← 0;
  - partial-sum shift register ← 0;
  - next state RUN.
- IDLE with `START`=0 stays in IDLE.
- FIN with `START`=0 goes to IDLE.
- RUN, on each edge:
  - partial-sum ← {FullAdder.SUM, partial-sum[WIDTH-1:1]}, so the sum shifts in at the MSB;
  - A/B shift registers shift right by 1;
  - carry flip-flop ← FullAdder.CARRY;
  - counter increments.
- RUN on the edge where counter = WIDTH-1:
  - `SUM` ← final partial-sum, including this edge's bit;
  - `COUT` ← FullAdder.CARRY;
  - next state FIN.
- `START` in RUN is ignored. It is not queued and the operands are not re-sampled.
- `SUM`/`COUT` change only on the completing edge. They keep the previous result during RUN.
- Arithmetic is unsigned modulo 2^WIDTH. {COUT,SUM} = A + B + CIN exactly.
- Counter width is clog2(WIDTH). The counter must never wrap within one operation.

## Timing
- Reset values:
  - `SUM`=0, `COUT`=0, `BUSY`=0, `DONE`=0;
  - state IDLE;
  - counter, shift registers and carry flip-flop all 0.
- `RST` has priority over `START` on the same edge.
- `RST` asserted in RUN aborts the operation. `SUM`/`COUT` are forced to 0 and no `DONE` is produced.
- For an accepting edge E0:
  - `BUSY`=1 in cycles E0+1 … E0+WIDTH, i.e. WIDTH cycles;
  - the result updates on edge E0+WIDTH;
  - `DONE`=1 for exactly the one cycle after E0+WIDTH, with `BUSY`=0 in that cycle;
  - latency from `START` to valid `SUM` is WIDTH clocks.
- `BUSY` and `DONE` are registered outputs, decoded from state: `BUSY` = (state==RUN), `DONE` = (state==FIN).
- Back-to-back: `START` held high in the `DONE` cycle begins the next operation with no idle cycle. Throughput is one result per WIDTH+1 cycles.
- `START` held high continuously restarts on every FIN.

## Test plan
- WIDTH=8; `RST` 2 cycles; A=0x00, B=0x00, CIN=0; `START` pulse:
  - `BUSY` high 8 cycles, then `DONE` 1 cycle;
  - `SUM`=0x00, `COUT`=0.
- A=0xFF, B=0x01, CIN=0 → `SUM`=0x00, `COUT`=1, valid on the `DONE` cycle 8 clocks after `START`.
- A=0xFF, B=0xFF, CIN=1 → `SUM`=0xFF, `COUT`=1. A=0xA5, B=0x5A, CIN=0 → `SUM`=0xFF, `COUT`=0.
- Change A/B and pulse `START` at cycle 3 of RUN:
  - result still reflects the original operands;
  - exactly one `DONE`;
  - `SUM` holds the prior result until completion.
- Assert `RST` at cycle 4 of RUN with A=0x0F, B=0x01:
  - next cycle `BUSY`=0, `SUM`=0x00, `COUT`=0;
  - no `DONE` pulse.
- Hold `START`=1 with A=0x10, B=0x20, then A=0x7F, B=0x01 presented in the first `DONE` cycle:
  - `DONE` pulses 9 cycles apart;
  - `SUM` reads 0x30, then 0x80, with `COUT`=0 both times.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FullAdder cell processes one bit pair per clock,
// LSB first, with the carry held in a flip-flop between bits.

module FullAdder (
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic SUM,
  output logic CARRY
);
  assign SUM   = A ^ B ^ CIN;
  assign CARRY = (A & B) | (CIN & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] psum_nxt;

  FullAdder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .CIN  (carry),
    .SUM  (fa_sum),
    .CARRY(fa_carry)
  );

  // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign psum_nxt = {fa_sum, psum[WIDTH-1:1]};

  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (START) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= CIN;
            cnt   <= '0;
            psum  <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          psum  <= psum_nxt;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_carry;
          if (cnt == LAST) begin
            // Counter is held rather than incremented so it never wraps for power-of-two widths.
            SUM   <= psum_nxt;
            COUT  <= fa_carry;
            state <= FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, corner sequences
// and randomized operations against an arithmetic reference.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  serial_adder #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .START(start), .A(a), .B(b), .CIN(cin),
    .BUSY(busy), .DONE(done), .SUM(sum), .COUT(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start one operation and follow it to DONE, checking handshake timing and result.
  task automatic run_op(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input logic [W-1:0] es, input logic ec);
    int nbusy;
    logic held;
    logic [W-1:0] prev_sum;
    logic prev_cout;
    @(negedge clk);
    prev_sum  = sum;
    prev_cout = cout;
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; cin = ~vc;
    nbusy = 0;
    held  = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) nbusy++;
      if (sum !== prev_sum || cout !== prev_cout) held = 1'b0;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, nbusy, W);
    chk({nm, " held"}, held, 1'b1);
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " busy_in_done"}, busy, 1'b0);
    chk({nm, " sum"}, sum, es);
    chk({nm, " cout"}, cout, ec);
    @(negedge clk);
    chk({nm, " done_pulse"}, done, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W:0] model;
    int ndone, t1, t2;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout);

    // START and new operands during RUN must be ignored.
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    chk("midrun sum_held", sum, 8'h80);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        ndone++;
        chk("midrun sum", sum, 8'h07);
        chk("midrun cout", cout, 1'b0);
      end
      @(negedge clk);
    end
    chk("midrun done_count", ndone, 1);

    // Reset in the middle of an operation aborts it.
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort no_done", ndone, 0);

    // START held high: back-to-back operations with no idle cycle.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      @(negedge clk);
      if (done) t1 = cyc;
    end
    chk("b2b first_done", (t1 >= 0), 1);
    chk("b2b sum1", sum, 8'h30);
    chk("b2b cout1", cout, 0);
    a = 8'h7F; b = 8'h01;
    for (int i = 0; i < 30 && t2 < 0; i++) begin
      @(negedge clk);
      if (done) t2 = cyc;
    end
    start = 1'b0;
    chk("b2b spacing", t2 - t1, 9);
    chk("b2b sum2", sum, 8'h80);
    chk("b2b cout2", cout, 0);
    repeat (2) @(negedge clk);

    // Randomized operations against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op($sformatf("rand%0d", i), ra, rb, rc, model[W-1:0], model[W]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
